// File: rtl/dmg_lcd_capture_if.sv
// -----------------------------------------------------------------------------
// dmg_lcd_capture_if
// Bundles the DMG LCD pin set with the framebuffer write port so that the
// capture block sits between the two with a single connection.
//   lcd_clk, lcd_d0, lcd_d1  pixel clock and inverted 2-bit pixel data
//   lcd_hsync, lcd_vsync     line and frame sync, active high
//   wr_en, wr_addr, wr_data  framebuffer write strobe, linear address, pixel
// Modports:
//   master  drives the LCD pins and observes the framebuffer writes
//   slave   the capture block: reads the LCD pins, issues framebuffer writes
// -----------------------------------------------------------------------------
interface dmg_lcd_capture_if;
    logic        lcd_clk;
    logic        lcd_d0;
    logic        lcd_d1;
    logic        lcd_hsync;
    logic        lcd_vsync;
    logic        wr_en;
    logic [14:0] wr_addr;
    logic [1:0]  wr_data;

    modport master (
        output lcd_clk, lcd_d0, lcd_d1, lcd_hsync, lcd_vsync,
        input  wr_en, wr_addr, wr_data
    );

    modport slave (
        input  lcd_clk, lcd_d0, lcd_d1, lcd_hsync, lcd_vsync,
        output wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/dmg_lcd_capture.sv
// -----------------------------------------------------------------------------
// dmg_lcd_capture
// Watches the DMG LCD bus (asynchronous to clk_32m) and rebuilds the image as
// a stream of framebuffer writes, one per pixel, at address y*HPIX + x.
// Ports:
//   clk_32m     system clock, at least 6x the LCD pixel clock
//   rst_n       asynchronous active-low reset
//   enable      capture enable; low forces the hunt for the next frame start
//   err_clr     one-cycle pulse clearing the sticky error flags
//   bus         LCD pins in, framebuffer write port out (slave modport)
//   frame_done  one-cycle pulse in the cycle after the last pixel write
//   overrun     sticky: more than HPIX pixel clocks seen in one line
//   short_line  sticky: a line ended with fewer than HPIX pixels
//   sync_err    sticky: vsync arrived before the frame completed
// -----------------------------------------------------------------------------
module dmg_lcd_capture #(
    parameter int HPIX = 160,
    parameter int VPIX = 144
) (
    input  logic                     clk_32m,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic                     err_clr,
    dmg_lcd_capture_if.slave         bus,
    output logic                     frame_done,
    output logic                     overrun,
    output logic                     short_line,
    output logic                     sync_err
);

    localparam logic [7:0]  HPIX_L    = 8'(HPIX);
    localparam logic [7:0]  VPIX_L    = 8'(VPIX);
    localparam logic [14:0] LINE_STEP = 15'(HPIX);

    typedef enum logic [1:0] {SEEK, HSYNC, PIXELS} state_t;

    // Synchronizer bit order: {vsync, hsync, d1, d0, clk}
    logic [4:0] s1;
    logic [4:0] s2;
    logic       s3_clk;
    logic       s3_hs;

    always_ff @(posedge clk_32m or negedge rst_n) begin
        if (!rst_n) begin
            s1     <= '0;
            s2     <= '0;
            s3_clk <= 1'b0;
            s3_hs  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make each stage take the previous
            // stage's old value, so this really is a three-deep shift chain.
            s1     <= {bus.lcd_vsync, bus.lcd_hsync, bus.lcd_d1, bus.lcd_d0, bus.lcd_clk};
            s2     <= s1;
            s3_clk <= s2[0];
            s3_hs  <= s2[3];
        end
    end

    logic clk_fall;
    logic hs_rise;
    logic hs_fall;
    logic vs;

    assign clk_fall = s3_clk & ~s2[0];
    assign hs_rise  = ~s3_hs & s2[3];
    assign hs_fall  = s3_hs & ~s2[3];
    assign vs       = s2[4];

    state_t      state;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [14:0] line_base;
    logic        done_pend;

    always_ff @(posedge clk_32m or negedge rst_n) begin
        if (!rst_n) begin
            state       <= SEEK;
            x           <= '0;
            y           <= '0;
            line_base   <= '0;
            done_pend   <= 1'b0;
            bus.wr_en   <= 1'b0;
            bus.wr_addr <= '0;
            bus.wr_data <= '0;
            frame_done  <= 1'b0;
            overrun     <= 1'b0;
            short_line  <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            bus.wr_en  <= 1'b0;
            done_pend  <= 1'b0;
            frame_done <= done_pend;

            // Clear first; any flag set further down in the same cycle
            // overrides this because the later assignment wins.
            if (err_clr) begin
                overrun    <= 1'b0;
                short_line <= 1'b0;
                sync_err   <= 1'b0;
            end

            if (!enable) begin
                state <= SEEK;
            end else begin
                case (state)
                    SEEK: begin
                        if (hs_rise && vs) begin
                            y         <= '0;
                            line_base <= '0;
                            state     <= HSYNC;
                        end
                    end

                    // Pixel clocks while hsync is high are not pixels.
                    HSYNC: begin
                        if (hs_fall) begin
                            x     <= '0;
                            state <= PIXELS;
                        end
                    end

                    PIXELS: begin
                        if (hs_rise) begin
                            if (x < HPIX_L) short_line <= 1'b1;
                            if (vs) begin
                                sync_err  <= 1'b1;
                                y         <= '0;
                                line_base <= '0;
                            end else begin
                                y         <= y + 8'd1;
                                line_base <= line_base + LINE_STEP;
                            end
                            state <= HSYNC;
                        end else if (clk_fall) begin
                            if (x < HPIX_L) begin
                                // Data is sampled mid-pixel; the bus carries it inverted.
                                bus.wr_en   <= 1'b1;
                                bus.wr_addr <= line_base + {7'd0, x};
                                bus.wr_data <= ~s2[2:1];
                                x           <= x + 8'd1;
                                if (x == HPIX_L - 8'd1 && y == VPIX_L - 8'd1) begin
                                    done_pend <= 1'b1;
                                    state     <= SEEK;
                                end
                            end else begin
                                overrun <= 1'b1;
                            end
                        end
                    end

                    default: state <= SEEK;
                endcase
            end
        end
    end

endmodule
